// File: rtl/noc_mux_pkg.sv
// Shared constants and helpers for the NoC 2:1 merge primitive.
// Build option: MUX_OUT_REG_EN (see mux_2x1_comb.sv).
package noc_mux_pkg;

   localparam logic CMD_SEL_LOW  = 1'b0;
   localparam logic CMD_SEL_HIGH = 1'b1;

   localparam int LANE_LOW  = 0;
   localparam int LANE_HIGH = 1;

   // One bit of the dummy pattern; replicate to any width for the all-zero value.
   function automatic logic zero_fill_bit();
      return 1'b0;
   endfunction

   // One-hot lane select derived from enable and command bit 0.
   function automatic logic [1:0] lane_sel_onehot(input logic en, input logic cmd0);
      logic [1:0] sel;
      sel            = 2'b00;
      sel[LANE_HIGH] = en & (cmd0 == CMD_SEL_HIGH);
      sel[LANE_LOW]  = en & (cmd0 == CMD_SEL_LOW);
      return sel;
   endfunction

endpackage

// File: rtl/mux_2x1_comb_lane_gate.sv
// Single-lane gate: passes the lane's data and valid only when the lane is
// both selected and valid, otherwise drives zero. Two of these are ORed.
module mux_lane_gate #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  sel_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic pass;

   // AND-gate the lane so an unselected or invalid lane contributes all zeros.
   always_comb begin
      pass    = sel_i & valid_i;
      valid_o = pass;
      data_o  = data_i & {DATA_WIDTH{pass}};
   end

endmodule

// File: rtl/mux_2x1_comb.sv
// 2:1 valid-qualified data mux for the NoC switch fabric, with a sticky
// select-error sideband flag.
// Build option: define MUX_OUT_REG_EN to register o_valid/o_data_bus (1-cycle
// latency); when undefined the data path is purely combinational.
module mux_2x1_comb
   import noc_mux_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int COMMMAND_WIDTH = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                i_valid,
   input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
   input  logic                      i_en,
   input  logic [COMMMAND_WIDTH-1:0] i_cmd,
   output logic                      o_valid,
   output logic [DATA_WIDTH-1:0]     o_data_bus,
   output logic                      o_sel_err
);

   logic [1:0]                 sel_oh;
   logic [1:0]                 lane_vld;
   logic [1:0][DATA_WIDTH-1:0] lane_data;
   logic                       mux_valid;
   logic [DATA_WIDTH-1:0]      mux_data;
   logic                       sel_err_q;
   logic                       sel_err_d;

   // Decode enable and command bit 0 into a one-hot lane select.
   always_comb begin
      sel_oh = lane_sel_onehot(i_en, i_cmd[0]);
   end

   for (genvar g = 0; g < 2; g++) begin : g_lane
      mux_lane_gate #(.DATA_WIDTH(DATA_WIDTH)) u_gate (
         .sel_i   (sel_oh[g]),
         .valid_i (i_valid[g]),
         .data_i  (i_data_bus[g*DATA_WIDTH +: DATA_WIDTH]),
         .valid_o (lane_vld[g]),
         .data_o  (lane_data[g])
      );
   end

   // OR the two gated lanes; at most one can be non-zero.
   always_comb begin
      mux_valid = lane_vld[LANE_HIGH] | lane_vld[LANE_LOW];
      mux_data  = lane_data[LANE_HIGH] | lane_data[LANE_LOW];
   end

   // An enabled selection that produced no valid means the chosen lane was invalid.
   always_comb begin
      sel_err_d = sel_err_q | (i_en & ~mux_valid);
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sel_err_q <= 1'b0;
      else     sel_err_q <= sel_err_d;
   end

   assign o_sel_err = sel_err_q;

`ifdef MUX_OUT_REG_EN
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;

   // Output register; gated data is already zero when invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= {DATA_WIDTH{zero_fill_bit()}};
      end else begin
         valid_q <= mux_valid;
         data_q  <= mux_data;
      end
   end

   assign o_valid    = valid_q;
   assign o_data_bus = data_q;
`else
   assign o_valid    = mux_valid;
   assign o_data_bus = mux_data;
`endif

endmodule

// File: tb/tb_mux_2x1_comb.sv
// Scoreboard bench for mux_2x1_comb; expected outputs are queued when inputs
// are driven and compared once the DUT output has settled.
module tb_mux_2x1_comb;

   localparam int DW = 32;

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      string         name;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    i_valid;
   logic [2*DW-1:0] i_data_bus;
   logic          i_en;
   logic [0:0]    i_cmd;
   logic          o_valid;
   logic [DW-1:0] o_data_bus;
   logic          o_sel_err;

   exp_t sb[$];
   exp_t e;
   logic err_m;
   int   total = 0;
   int   bad   = 0;

   mux_2x1_comb #(.DATA_WIDTH(DW), .COMMMAND_WIDTH(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_data_bus (i_data_bus),
      .i_en       (i_en),
      .i_cmd      (i_cmd),
      .o_valid    (o_valid),
      .o_data_bus (o_data_bus),
      .o_sel_err  (o_sel_err)
   );

   always #5 clk = ~clk;

   // Drive inputs at the current negedge and queue the model's expectation.
   task automatic drive(input logic en, input logic cmd, input logic [1:0] v,
                        input logic [DW-1:0] hi, input logic [DW-1:0] lo, input string nm);
      exp_t x;
      logic sv;
      i_en = en; i_cmd = cmd; i_valid = v; i_data_bus = {hi, lo};
      sv = cmd ? v[1] : v[0];
      x.v = en & sv;
      x.d = x.v ? (cmd ? hi : lo) : '0;
      x.name = nm;
      sb.push_back(x);
      if (en && !sv) err_m = 1'b1;
   endtask

   // Wait until the data output for the last drive is observable.
   task automatic settle();
`ifdef MUX_OUT_REG_EN
      @(posedge clk); #1;
`else
      #1;
`endif
   endtask

   // Make sure the edge that updates the error flag has passed.
   task automatic past_edge();
`ifndef MUX_OUT_REG_EN
      @(posedge clk); #1;
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; i_en = 0; i_cmd = 0; i_valid = 0; i_data_bus = '0; err_m = 0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (o_sel_err !== 1'b0 || o_valid !== 1'b0 || o_data_bus !== '0) begin
         bad++;
         $display("FAIL reset: err=%b v=%b d=%h want 0/0/0", o_sel_err, o_valid, o_data_bus);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_disabled();
      drive(0, 1, 2'b11, 32'hFFFFFFFF, 32'hAAAAAAAA, "disabled");
      settle(); e = sb.pop_front();
      total++;
      if (o_valid !== e.v || o_data_bus !== e.d) begin
         bad++; $display("FAIL %s: v=%b d=%h want v=%b d=%h", e.name, o_valid, o_data_bus, e.v, e.d);
      end
      past_edge();
      total++;
      if (o_sel_err !== err_m) begin
         bad++; $display("FAIL disabled_err: got %b want %b", o_sel_err, err_m);
      end
      @(negedge clk);
   endtask

   task automatic test_select();
      drive(1, 1, 2'b10, 32'hFFFFFFFF, 32'hAAAAAAAA, "sel_high");
      settle(); e = sb.pop_front();
      total++;
      if (o_valid !== e.v || o_data_bus !== e.d) begin
         bad++; $display("FAIL %s: v=%b d=%h want v=%b d=%h", e.name, o_valid, o_data_bus, e.v, e.d);
      end
      @(negedge clk);
      drive(1, 0, 2'b01, 32'hFFFFFFFF, 32'hAAAAAAAA, "sel_low");
      settle(); e = sb.pop_front();
      total++;
      if (o_valid !== e.v || o_data_bus !== e.d) begin
         bad++; $display("FAIL %s: v=%b d=%h want v=%b d=%h", e.name, o_valid, o_data_bus, e.v, e.d);
      end
      past_edge();
      total++;
      if (o_sel_err !== 1'b0) begin
         bad++; $display("FAIL select_err: got %b want 0", o_sel_err);
      end
      @(negedge clk);
   endtask

   task automatic test_invalid();
      drive(1, 1, 2'b01, 32'hFFFFFFFF, 32'hAAAAAAAA, "inv_high");
      settle(); e = sb.pop_front();
      total++;
      if (o_valid !== e.v || o_data_bus !== e.d) begin
         bad++; $display("FAIL %s: v=%b d=%h want v=%b d=%h", e.name, o_valid, o_data_bus, e.v, e.d);
      end
      past_edge();
      total++;
      if (o_sel_err !== 1'b1) begin
         bad++; $display("FAIL inv_high_err: got %b want 1", o_sel_err);
      end
      @(negedge clk);
      drive(1, 0, 2'b10, 32'hFFFFFFFF, 32'hAAAAAAAA, "inv_low");
      settle(); e = sb.pop_front();
      total++;
      if (o_valid !== e.v || o_data_bus !== e.d) begin
         bad++; $display("FAIL %s: v=%b d=%h want v=%b d=%h", e.name, o_valid, o_data_bus, e.v, e.d);
      end
      @(negedge clk);
      drive(1, 0, 2'b01, 32'h00000000, 32'hFFFFFFFF, "low_after_change");
      settle(); e = sb.pop_front();
      total++;
      if (o_valid !== e.v || o_data_bus !== e.d) begin
         bad++; $display("FAIL %s: v=%b d=%h want v=%b d=%h", e.name, o_valid, o_data_bus, e.v, e.d);
      end
      past_edge();
      total++;
      if (o_sel_err !== 1'b1) begin
         bad++; $display("FAIL sticky_err: got %b want 1", o_sel_err);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), $urandom, $urandom, "random");
         settle(); e = sb.pop_front();
         total++;
         if (o_valid !== e.v || o_data_bus !== e.d) begin
            bad++; $display("FAIL %s[%0d]: v=%b d=%h want v=%b d=%h", e.name, i, o_valid, o_data_bus, e.v, e.d);
         end
         past_edge();
         total++;
         if (o_sel_err !== err_m) begin
            bad++; $display("FAIL random_err[%0d]: got %b want %b", i, o_sel_err, err_m);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_run();
      // Make sure the flag is set before the reset is applied.
      drive(1, 1, 2'b01, 32'h0, 32'h0, "pre_rst_inv");
      settle(); void'(sb.pop_front()); past_edge(); @(negedge clk);
      drive(1, 1, 2'b10, 32'hFFFFFFFF, 32'hAAAAAAAA, "rst_hold");
      settle(); void'(sb.pop_front());
      @(negedge clk); #2;
      total++;
      if (o_sel_err !== 1'b1) begin
         bad++; $display("FAIL pre_rst_err: got %b want 1", o_sel_err);
      end
      rst = 1'b1; #1;
      total++;
      if (o_sel_err !== 1'b0) begin
         bad++; $display("FAIL rst_async_err: got %b want 0", o_sel_err);
      end
`ifdef MUX_OUT_REG_EN
      total++;
      if (o_valid !== 1'b0 || o_data_bus !== '0) begin
         bad++; $display("FAIL rst_reg_out: v=%b d=%h want 0/0", o_valid, o_data_bus);
      end
`else
      total++;
      if (o_valid !== 1'b1 || o_data_bus !== 32'hFFFFFFFF) begin
         bad++; $display("FAIL rst_comb_out: v=%b d=%h want 1/ffffffff", o_valid, o_data_bus);
      end
`endif
      @(negedge clk); rst = 1'b0; err_m = 1'b0;
      drive(1, 1, 2'b10, 32'h12345678, 32'hAAAAAAAA, "post_rst");
      settle(); e = sb.pop_front();
      total++;
      if (o_valid !== e.v || o_data_bus !== e.d) begin
         bad++; $display("FAIL %s: v=%b d=%h want v=%b d=%h", e.name, o_valid, o_data_bus, e.v, e.d);
      end
      past_edge();
      total++;
      if (o_sel_err !== 1'b0) begin
         bad++; $display("FAIL post_rst_err: got %b want 0", o_sel_err);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_disabled();
      test_select();
      test_invalid();
      test_back_to_back();
      test_reset_mid_run();
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain: left=%0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_2x1_comb.md
Name: mux_2x1_comb

Overview:
Two-input, one-output data multiplexer for the NoC switch fabric, with valid qualification. Output data is combinational from the inputs: select the high or low half of a packed input bus by command, gated by enable and the chosen input's valid. A small clocked sideband holds a sticky error flag for selections of invalid inputs. It sits inside router/distribution tree nodes as the 2:1 merge primitive.

Parameters:
DATA_WIDTH, 32, width of each data lane and of the output.
COMMMAND_WIDTH, 1, width of i_cmd; only bit 0 is decoded, the upper bits are ignored.

Ports:
clk  input  1  clock for sideband/optional registers.
rst  input  1  asynchronous, active-high reset.
i_valid  input  2  per-lane valid; [1]=high lane, [0]=low lane.
i_data_bus  input  2*DATA_WIDTH  packed lanes; high=[2*DATA_WIDTH-1:DATA_WIDTH], low=[DATA_WIDTH-1:0].
i_en  input  1  mux enable.
i_cmd  input  COMMMAND_WIDTH  select; bit0=1 selects high, bit0=0 selects low.
o_valid  output  1  output valid.
o_data_bus  output  DATA_WIDTH  selected data, or all-zero dummy.
o_sel_err  output  1  sticky flag: an enabled selection pointed at an invalid lane.

Behaviour:
- Combinational path, zero latency:
  - i_en=0: o_valid=0, o_data_bus=0.
  - i_en=1, i_cmd[0]=1: o_valid=i_valid[1]; o_data_bus=high lane if i_valid[1], else 0.
  - i_en=1, i_cmd[0]=0: o_valid=i_valid[0]; o_data_bus=low lane if i_valid[0], else 0.
- Invariant: o_data_bus is all-zero whenever o_valid=0. The non-selected lane's valid and data never affect the outputs.
- X-safety: the data mux is an explicit AND-OR of the two lanes with one-hot selects. No latches. The combinational path does not depend on rst.
- o_sel_err:
  - Set on a rising clk edge when i_en=1 and the selected lane's valid=0.
  - Stays set until rst. rst=1 clears it to 0 asynchronously.
  - Asserting rst mid-operation does not disturb the combinational outputs.
- Simultaneous events: changes to i_cmd, i_en and i_data_bus in the same instant resolve purely combinationally. No ordering dependence.

Optional Feature:
MUX_OUT_REG_EN
- Defined: o_valid and o_data_bus are registered on clk, giving 1-cycle latency.
  - Reset values: o_valid=0, o_data_bus=0, asynchronous on rst.
  - The zero-data-when-invalid invariant holds at the register output.
  - o_sel_err keeps its sticky semantics, unchanged.
- Undefined: the pure combinational path described above; clk/rst drive only o_sel_err.

Decomposition:
- Shared package noc_mux_pkg holds:
  - CMD_SEL_LOW=1'b0 and CMD_SEL_HIGH=1'b1 constants.
  - The lane index constants LANE_LOW=0 and LANE_HIGH=1.
  - A DATA_WIDTH-independent helper for the zero dummy value.
- One natural sub-module, mux_lane_gate: gates a single lane's data by (select AND valid). It is instantiated twice and the two results are ORed.

Test Plan:
- Disabled: rst pulse, then i_en=0, i_cmd=1, i_valid=2'b11, high=32'hFFFFFFFF, low=32'hAAAAAAAA -> o_valid=0, o_data_bus=0, o_sel_err=0.
- Select high: i_en=1, i_cmd=1, i_valid=2'b10 -> o_valid=1, o_data_bus=32'hFFFFFFFF.
- Select low: i_en=1, i_cmd=0, i_valid=2'b01 -> o_valid=1, o_data_bus=32'hAAAAAAAA.
- Invalid high selected: i_en=1, i_cmd=1, i_valid=2'b01 -> o_valid=0, o_data_bus=0; o_sel_err=1 after next clk edge and stays 1.
- Invalid low selected, then data change:
  - i_cmd=0, i_valid=2'b10 -> o_valid=0, o_data_bus=0.
  - Then i_valid=2'b01, high=0, low=32'hFFFFFFFF -> o_valid=1, o_data_bus=32'hFFFFFFFF.
- Reset and option:
  - rst asserted mid-run -> o_sel_err=0 immediately.
  - With MUX_OUT_REG_EN, the select-high case yields o_data_bus=32'hFFFFFFFF exactly one clk later; o_data_bus=0 during rst.
